// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide SDRAM controller port
// among toggle-handshake clients, one transaction in flight at a time.
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int RD_GAP    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PORTS-1:0]      c_req,
    output logic [NUM_PORTS-1:0]      c_ack,
    input  logic [NUM_PORTS-1:0]      c_we,
    input  logic [25*NUM_PORTS-1:0]   c_addr,
    input  logic [8*NUM_PORTS-1:0]    c_din,
    output logic [7:0]                c_dout,
    output logic [24:0]               sd_raddr,
    output logic                      sd_rd,
    input  logic                      sd_rd_rdy,
    input  logic [7:0]                sd_dout,
    output logic [24:0]               sd_waddr,
    output logic [7:0]                sd_din,
    output logic                      sd_we,
    input  logic                      sd_we_ack
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int GW = $clog2(RD_GAP + 1);

    typedef enum logic [2:0] {
        IDLE, WR, RD_GAPW, RD_BUSY, RD_DATA, DONE
    } state_t;

    state_t               state, state_nx;
    logic [NUM_PORTS-1:0] pending;
    logic [PW-1:0]        rr, grant, sel;
    logic                 found;
    int                   idx;
    logic [24:0]          addr_r;
    logic [GW-1:0]        gap;
    logic                 grab, wr_go, rd_go, rd_fin, ack_go;

    assign pending = c_req ^ c_ack;

    // First pending port at or after the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr) + k;
            if (idx >= NUM_PORTS)
                idx = idx - NUM_PORTS;
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:
                if (found)
                    state_nx = c_we[sel] ? WR : RD_GAPW;
            WR:
                if (sd_we_ack == sd_we)
                    state_nx = DONE;
            RD_GAPW:
                if (gap == '0 && sd_rd_rdy)
                    state_nx = RD_BUSY;
            RD_BUSY:
                if (!sd_rd_rdy)
                    state_nx = RD_DATA;
            RD_DATA:
                if (sd_rd_rdy)
                    state_nx = DONE;
            DONE:
                state_nx = IDLE;
            default:
                state_nx = IDLE;
        endcase
    end

    always_comb begin
        grab   = (state == IDLE) && found;
        wr_go  = grab && c_we[sel];
        rd_go  = (state == RD_GAPW) && (gap == '0) && sd_rd_rdy;
        rd_fin = (state == RD_DATA) && sd_rd_rdy;
        ack_go = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_ack    <= '0;
            c_dout   <= '0;
            sd_rd    <= 1'b0;
            sd_raddr <= '0;
            sd_waddr <= '0;
            sd_din   <= '0;
            sd_we    <= sd_we_ack;
            rr       <= '0;
            grant    <= '0;
            addr_r   <= '0;
            gap      <= GW'(RD_GAP);
        end else begin
            if (gap != '0)
                gap <= gap - GW'(1);
            if (grab) begin
                grant  <= sel;
                addr_r <= c_addr[25*sel +: 25];
                rr     <= (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + PW'(1);
            end
            if (wr_go) begin
                sd_waddr <= c_addr[25*sel +: 25];
                sd_din   <= c_din[8*sel +: 8];
                sd_we    <= ~sd_we;
            end
            if (rd_go) begin
                sd_raddr <= addr_r;
                sd_rd    <= 1'b1;
            end
            // Reload after each read so the next rd edge is spaced out.
            if (rd_fin) begin
                c_dout <= sd_dout;
                sd_rd  <= 1'b0;
                gap    <= GW'(RD_GAP);
            end
            if (ack_go)
                c_ack[grant] <= c_req[grant];
        end
    end

endmodule
